// File: rtl/etroc_link_pkg.sv
// Shared definitions for the ETROC link synchronisation logic:
// FSM state encodings, lock-condition bit positions and the lock-condition helper.
package etroc_link_pkg;

   localparam int STATE_W = 3;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RESYNC    = 3'd1;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
   localparam logic [2:0] ST_LOCKED    = 3'd3;
   localparam logic [2:0] ST_FAIL      = 3'd4;

   // Bit positions of the lock-condition inputs when packed into one vector
   localparam int LC_ALIGNED      = 0;
   localparam int LC_TRIG_SYNCHED = 1;
   localparam int LC_TRIG_ERROR   = 2;
   localparam int LC_CONSISTENT   = 3;
   localparam int LC_W            = 4;

   // Link is considered lockable when aligned, trigger synchronised and error free,
   // optionally also requiring the data/trigger word offsets to agree
   function automatic logic lockCondFn(input logic [LC_W-1:0] lcBits, input logic consistReq);
      return lcBits[LC_ALIGNED] & lcBits[LC_TRIG_SYNCHED] & ~lcBits[LC_TRIG_ERROR]
             & (lcBits[LC_CONSISTENT] | ~consistReq);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk40,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] count_r;

   // Count up on inc, hold at all-ones, clear wins over increment
   always_ff @(posedge clk40 or negedge reset) begin
      if (!reset) begin
         count_r <= {WIDTH{1'b0}};
      end else if (clr) begin
         count_r <= {WIDTH{1'b0}};
      end else if (inc && (count_r != {WIDTH{1'b1}})) begin
         count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign q = count_r;

endmodule

// File: rtl/link_sync_ctrl.sv
// Link (re)synchronisation sequencer for one dataExtract channel.
// Pulses the resync outputs, waits for a stable lock, watches the data error
// rate in a sliding window and re-locks with a bounded number of retries.
module link_sync_ctrl
   import etroc_link_pkg::*;
#(
   parameter int RESYNC_PULSE = 4,
   parameter int LOCK_HOLD    = 16,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int ERR_WINDOW   = 1024,
   parameter int ERR_THRESH   = 8,
   parameter int MAX_RETRY    = 15,
   parameter bit CONSIST_REQ  = 1'b1
) (
   input  logic               clk40,
   input  logic               reset,
   input  logic               enableAutoSync,
   input  logic               clrError,
   input  logic               forceResync,
   input  logic               aligned,
   input  logic               dataError,
   input  logic               dataValid,
   input  logic               trigSynched,
   input  logic               trigError,
   input  logic               linkConsistent,
   output logic               resyncData,
   output logic               resyncTrig,
   output logic               linkLocked,
   output logic               linkFail,
   output logic [STATE_W-1:0] state,
   output logic [7:0]         retryCount,
   output logic [15:0]        dataErrCount
);

   localparam logic [7:0]  PULSE_LAST = 8'(RESYNC_PULSE - 1);
   localparam logic [7:0]  HOLD_LAST  = 8'(LOCK_HOLD - 1);
   localparam logic [15:0] TO_LAST    = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] WIN_LAST   = 16'(ERR_WINDOW - 1);

   logic [STATE_W-1:0] state_r, stateNext_s, relockState_s;
   logic [7:0]  pulseCnt_r, holdCnt_r;
   logic [15:0] timeoutCnt_r, winCnt_r, winErr_r, winErrNext_s;
   logic        resyncData_r, resyncTrig_r, linkLocked_r, linkFail_r;
   logic        lockCond_s, errStrobe_s, lockHit_s, timeoutHit_s, retryFull_s;
   logic        winWrap_s, lockLoss_s, retryInc_s, retryClr_s, dataErrInc_s;
   logic [7:0]  retryCount_s;

   assign lockCond_s    = lockCondFn({linkConsistent, trigError, trigSynched, aligned}, CONSIST_REQ);
   assign errStrobe_s   = dataValid & dataError;
   assign lockHit_s     = (state_r == ST_WAIT_LOCK) & lockCond_s & (holdCnt_r == HOLD_LAST);
   assign timeoutHit_s  = (state_r == ST_WAIT_LOCK) & (timeoutCnt_r == TO_LAST);
   assign retryFull_s   = ({1'b0, retryCount_s} + 9'd1) >= 9'(MAX_RETRY);
   assign winWrap_s     = (winCnt_r == WIN_LAST);
   // An error on the wrap cycle is the first error of the new window
   assign winErrNext_s  = winWrap_s ? {15'd0, errStrobe_s} : (winErr_r + {15'd0, errStrobe_s});
   assign lockLoss_s    = (winErrNext_s >= 16'(ERR_THRESH)) | ~aligned | trigError;
   assign relockState_s = enableAutoSync ? ST_RESYNC : ST_IDLE;
   assign dataErrInc_s  = errStrobe_s & (state_r != ST_RESYNC);

   // Next-state and retry-counter control; forceResync overrides every other transition
   always_comb begin
      stateNext_s = ST_IDLE;
      retryInc_s  = 1'b0;
      retryClr_s  = 1'b0;
      if (forceResync) begin
         stateNext_s = ST_RESYNC;
         retryClr_s  = (state_r == ST_FAIL);
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (enableAutoSync) stateNext_s = ST_RESYNC;
               else                stateNext_s = ST_IDLE;
            end
            ST_RESYNC: begin
               if (pulseCnt_r == PULSE_LAST) stateNext_s = ST_WAIT_LOCK;
               else                          stateNext_s = ST_RESYNC;
            end
            ST_WAIT_LOCK: begin
               if (lockHit_s) begin
                  stateNext_s = ST_LOCKED;
                  retryClr_s  = 1'b1;
               end else if (timeoutHit_s) begin
                  retryInc_s  = 1'b1;
                  stateNext_s = retryFull_s ? ST_FAIL : relockState_s;
               end else begin
                  stateNext_s = ST_WAIT_LOCK;
               end
            end
            ST_LOCKED: begin
               if (lockLoss_s) stateNext_s = relockState_s;
               else            stateNext_s = ST_LOCKED;
            end
            ST_FAIL: begin
               if (clrError) begin
                  stateNext_s = ST_IDLE;
                  retryClr_s  = 1'b1;
               end else begin
                  stateNext_s = ST_FAIL;
               end
            end
            default: stateNext_s = ST_IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk40 or negedge reset) begin
      if (!reset) state_r <= ST_IDLE;
      else        state_r <= stateNext_s;
   end

   // Resync pulse length; a forced restart begins the pulse count again
   always_ff @(posedge clk40 or negedge reset) begin
      if (!reset)                                      pulseCnt_r <= 8'd0;
      else if ((state_r == ST_RESYNC) && !forceResync) pulseCnt_r <= pulseCnt_r + 8'd1;
      else                                             pulseCnt_r <= 8'd0;
   end

   // Lock hold and timeout counters, only live while staying in WAIT_LOCK
   always_ff @(posedge clk40 or negedge reset) begin
      if (!reset) begin
         holdCnt_r    <= 8'd0;
         timeoutCnt_r <= 16'd0;
      end else if ((state_r == ST_WAIT_LOCK) && (stateNext_s == ST_WAIT_LOCK)) begin
         holdCnt_r    <= lockCond_s ? (holdCnt_r + 8'd1) : 8'd0;
         timeoutCnt_r <= timeoutCnt_r + 16'd1;
      end else begin
         holdCnt_r    <= 8'd0;
         timeoutCnt_r <= 16'd0;
      end
   end

   // Error-rate window, only live while staying in LOCKED
   always_ff @(posedge clk40 or negedge reset) begin
      if (!reset) begin
         winCnt_r <= 16'd0;
         winErr_r <= 16'd0;
      end else if ((state_r == ST_LOCKED) && (stateNext_s == ST_LOCKED)) begin
         winCnt_r <= winWrap_s ? 16'd0 : (winCnt_r + 16'd1);
         winErr_r <= winErrNext_s;
      end else begin
         winCnt_r <= 16'd0;
         winErr_r <= 16'd0;
      end
   end

   // Registered status outputs decoded from the current state
   always_ff @(posedge clk40 or negedge reset) begin
      if (!reset) begin
         resyncData_r <= 1'b0;
         resyncTrig_r <= 1'b0;
         linkLocked_r <= 1'b0;
         linkFail_r   <= 1'b0;
      end else begin
         resyncData_r <= (state_r == ST_RESYNC);
         resyncTrig_r <= (state_r == ST_RESYNC);
         linkLocked_r <= (state_r == ST_LOCKED);
         linkFail_r   <= (state_r == ST_FAIL);
      end
   end

   sat_counter #(.WIDTH(8)) uRetryCnt (
      .clk40 (clk40),
      .reset (reset),
      .inc   (retryInc_s),
      .clr   (retryClr_s),
      .q     (retryCount_s)
   );

   sat_counter #(.WIDTH(16)) uDataErrCnt (
      .clk40 (clk40),
      .reset (reset),
      .inc   (dataErrInc_s),
      .clr   (clrError),
      .q     (dataErrCount)
   );

   assign resyncData = resyncData_r;
   assign resyncTrig = resyncTrig_r;
   assign linkLocked = linkLocked_r;
   assign linkFail   = linkFail_r;
   assign state      = state_r;
   assign retryCount = retryCount_s;

endmodule

// File: tb/tb_link_sync_ctrl.sv
// Directed, scoreboard-based bench for link_sync_ctrl (MAX_RETRY=3, LOCK_TIMEOUT=64).
`timescale 1ns/1ps
module tb_link_sync_ctrl;

   logic clk40 = 1'b0;
   logic reset = 1'b0;
   logic enableAutoSync = 1'b0, clrError = 1'b0, forceResync = 1'b0;
   logic aligned = 1'b0, dataError = 1'b0, dataValid = 1'b0;
   logic trigSynched = 1'b0, trigError = 1'b0, linkConsistent = 1'b0;
   logic resyncData, resyncTrig, linkLocked, linkFail;
   logic [2:0]  state;
   logic [7:0]  retryCount;
   logic [15:0] dataErrCount;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] expQ[$];
   string       tagQ[$];

   link_sync_ctrl #(.MAX_RETRY(3), .LOCK_TIMEOUT(64)) dut (
      .clk40(clk40), .reset(reset), .enableAutoSync(enableAutoSync),
      .clrError(clrError), .forceResync(forceResync), .aligned(aligned),
      .dataError(dataError), .dataValid(dataValid), .trigSynched(trigSynched),
      .trigError(trigError), .linkConsistent(linkConsistent),
      .resyncData(resyncData), .resyncTrig(resyncTrig), .linkLocked(linkLocked),
      .linkFail(linkFail), .state(state), .retryCount(retryCount),
      .dataErrCount(dataErrCount)
   );

   always #5 clk40 = ~clk40;

   task automatic step(input int n);
      repeat (n) @(posedge clk40);
      #1;
   endtask

   task automatic expectVal(input string t, input logic [31:0] e);
      expQ.push_back(e);
      tagQ.push_back(t);
   endtask

   task automatic checkOut(input logic [31:0] obs);
      logic [31:0] e;
      string t;
      vectors++;
      if (expQ.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty: observed %0h expected none", obs);
      end else begin
         e = expQ.pop_front();
         t = tagQ.pop_front();
         assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, e);
         end
      end
   endtask

   task automatic setLock(input logic v);
      aligned = v;
      trigSynched = v;
      linkConsistent = v;
   endtask

   task automatic strobe(input logic withClr);
      dataValid = 1'b1;
      dataError = 1'b1;
      clrError = withClr;
      step(1);
      dataValid = 1'b0;
      dataError = 1'b0;
      clrError = 1'b0;
   endtask

   task automatic waitState(input logic [2:0] target, input int bound, input string t);
      int n;
      n = 0;
      expectVal(t, 32'd1);
      while ((state !== target) && (n < bound)) begin
         step(1);
         n++;
      end
      checkOut({31'd0, state === target});
   endtask

   initial begin
      int hi;
      int pulses;
      logic prev;

      // Reset state
      step(3);
      expectVal("rst_state", 32'd0); expectVal("rst_resync", 32'd0);
      expectVal("rst_locked", 32'd0); expectVal("rst_fail", 32'd0);
      expectVal("rst_retry", 32'd0); expectVal("rst_errcnt", 32'd0);
      checkOut(state); checkOut(resyncData); checkOut(linkLocked);
      checkOut(linkFail); checkOut(retryCount); checkOut(dataErrCount);
      reset = 1'b1;

      // T1: auto sync, lock condition from cycle 10
      enableAutoSync = 1'b1;
      hi = 0;
      for (int c = 1; c <= 10; c++) begin
         step(1);
         hi += int'(resyncData);
         if (c == 1) begin expectVal("t1_resync_state", 32'd1); checkOut(state); end
         if (c == 4) begin expectVal("t1_resync_last", 32'd1); checkOut(state); end
         if (c == 5) begin expectVal("t1_wait_state", 32'd2); checkOut(state); end
      end
      expectVal("t1_pulse_len", 32'd4);
      checkOut(hi);
      setLock(1'b1);
      expectVal("t1_hold15_wait", 32'd2);
      step(15); checkOut(state);
      expectVal("t1_hold16_locked", 32'd3); expectVal("t1_locked_lag", 32'd0);
      step(1); checkOut(state); checkOut(linkLocked);
      expectVal("t1_linklocked", 32'd1); expectVal("t1_retry", 32'd0);
      step(1); checkOut(linkLocked); checkOut(retryCount);

      // T3: 8 errors inside one window force a resync
      for (int s = 0; s < 8; s++) begin
         strobe(1'b0);
         if (s == 6) begin expectVal("t3_seven_errs_locked", 32'd3); checkOut(state); end
         if (s < 7) step(1);
      end
      expectVal("t3_eighth_err_resync", 32'd1); expectVal("t3_errcnt", 32'd8);
      checkOut(state); checkOut(dataErrCount);
      waitState(3'd3, 40, "t3_relock");

      // T4: 7 errors per window for 5 windows keeps the lock
      clrError = 1'b1;
      expectVal("t4_clr_errcnt", 32'd0);
      step(1);
      clrError = 1'b0;
      checkOut(dataErrCount);
      for (int i = 1; i < 5 * 1024; i++) begin
         dataValid = ((i % 1024) >= 10) && ((i % 1024) < 17);
         dataError = dataValid;
         step(1);
      end
      dataValid = 1'b0;
      dataError = 1'b0;
      expectVal("t4_still_locked", 32'd3); expectVal("t4_linklocked", 32'd1);
      expectVal("t4_errcnt35", 32'd35);
      checkOut(state); checkOut(linkLocked); checkOut(dataErrCount);

      // T2-style retry exhaustion: lock lost, never regained
      setLock(1'b0);
      pulses = 0;
      prev = 1'b0;
      for (int n = 0; n < 400; n++) begin
         step(1);
         if (resyncData && !prev) pulses++;
         prev = resyncData;
         if (linkFail) break;
      end
      expectVal("t2_linkfail", 32'd1); expectVal("t2_pulses", 32'd3);
      expectVal("t2_retry3", 32'd3); expectVal("t2_fail_state", 32'd4);
      expectVal("t2_fail_noresync", 32'd0);
      checkOut(linkFail); checkOut(pulses); checkOut(retryCount);
      checkOut(state); checkOut(resyncData);

      // T5: clrError leaves FAIL
      enableAutoSync = 1'b0;
      clrError = 1'b1;
      expectVal("t5_idle", 32'd0); expectVal("t5_retry_clr", 32'd0);
      expectVal("t5_errcnt_clr", 32'd0);
      step(1);
      clrError = 1'b0;
      checkOut(state); checkOut(retryCount); checkOut(dataErrCount);
      expectVal("t5_linkfail_drop", 32'd0);
      step(1); checkOut(linkFail);

      // T5: forceResync mid-pulse restarts the pulse
      forceResync = 1'b1;
      step(1);
      forceResync = 1'b0;
      hi = int'(resyncData);
      expectVal("t5_force_resync", 32'd1); checkOut(state);
      step(1);
      hi += int'(resyncData);
      forceResync = 1'b1;
      step(1);
      forceResync = 1'b0;
      hi += int'(resyncData);
      for (int k = 4; k <= 12; k++) begin
         step(1);
         hi += int'(resyncData);
         if (k == 6) begin expectVal("t5_restart_resync", 32'd1); checkOut(state); end
         if (k == 7) begin expectVal("t5_restart_wait", 32'd2); checkOut(state); end
      end
      expectVal("t5_restart_len", 32'd6);
      checkOut(hi);

      // T6: clear wins over a coincident error
      strobe(1'b0);
      expectVal("t6_err_one", 32'd1); checkOut(dataErrCount);
      strobe(1'b1);
      expectVal("t6_clr_wins", 32'd0); checkOut(dataErrCount);

      // T6: asynchronous reset while locked
      setLock(1'b1);
      enableAutoSync = 1'b1;
      waitState(3'd3, 40, "t6_lock");
      step(1);
      strobe(1'b0);
      expectVal("t6_locked", 32'd1); expectVal("t6_errcnt", 32'd1);
      checkOut(linkLocked); checkOut(dataErrCount);
      #2 reset = 1'b0;
      #1;
      expectVal("t6_async_locked", 32'd0); expectVal("t6_async_state", 32'd0);
      expectVal("t6_async_errcnt", 32'd0);
      checkOut(linkLocked); checkOut(state); checkOut(dataErrCount);

      // Reset during a resync pulse drops the resync outputs at once
      step(1);
      reset = 1'b1;
      hi = 0;
      for (int n = 0; n < 10; n++) begin
         step(1);
         if (resyncData) begin
            hi = 1;
            break;
         end
      end
      expectVal("t6_resync_seen", 32'd1); checkOut(hi);
      #2 reset = 1'b0;
      #1;
      expectVal("t6_async_resyncdata", 32'd0); expectVal("t6_async_resynctrig", 32'd0);
      checkOut(resyncData); checkOut(resyncTrig);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
